follower_amp_ctrl: RTL

Digital sequencer that drives the enable of an analog follower amplifier and brackets each use with a settle window. A fabric client requests a buffered sample. The block asserts `amp_ena` and waits a programmable settle time. It then presents a sample-valid window to the downstream sampler (ADC/comparator control) and, optionally, keeps the amplifier warm for back-to-back requests. It sits between the FPGA control fabric and the `ena` pin of the follower macro.

---
 rtl/follower_amp_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/follower_amp_ctrl.sv
// follower_amp_ctrl
//   Sequences the enable of an analog follower amplifier around each sample
//   request: enable, wait a programmable settle time, open a sample-valid
//   window to the downstream sampler, then optionally keep the amplifier warm
//   so that back-to-back requests skip the settle phase.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   cfg_settle : extra settle cycles after enable (captured at accept)
//   cfg_hold   : warm-hold cycles after a sample, 0 = no hold (captured at handshake)
//   req_valid  : client requests one sample
//   req_ready  : block can accept a request (IDLE or HOLD, not in abort/reset)
//   abort      : return to IDLE and drop the amplifier enable
//   smp_valid  : amplifier settled, sampling window open
//   smp_ready  : sampler has taken its sample
//   amp_ena    : registered enable to the follower macro
//   busy       : FSM is not in IDLE
//   sample_cnt : count of completed sample handshakes (wraps)
module follower_amp_ctrl #(
   parameter int SETTLE_W = 8,
   parameter int HOLD_W   = 8,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SETTLE_W-1:0] cfg_settle,
   input  logic [HOLD_W-1:0]   cfg_hold,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                abort,
   output logic                smp_valid,
   input  logic                smp_ready,
   output logic                amp_ena,
   output logic                busy,
   output logic [CNT_W-1:0]    sample_cnt
);

   // One down-counter serves both the settle and the hold phase.
   localparam int CW = (SETTLE_W > HOLD_W) ? SETTLE_W : HOLD_W;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      VALID,
      HOLD
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          handshake;

   // abort and rst mask the handshake signals so nothing is accepted or
   // counted in those cycles.
   assign req_ready = ((state == IDLE) || (state == HOLD)) && !abort && !rst;
   assign smp_valid = (state == VALID) && !abort;
   assign busy      = (state != IDLE);
   assign accept    = req_valid && req_ready;
   assign handshake = smp_valid && smp_ready;

   // amp_ena is assigned alongside every state transition so it always
   // equals (next state != IDLE), giving a glitch-free registered enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sample_cnt <= '0;
         amp_ena    <= 1'b0;
      end else if (abort) begin
         state   <= IDLE;
         amp_ena <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= SETTLE;
                  cnt     <= CW'(cfg_settle);
                  amp_ena <= 1'b1;
               end else begin
                  amp_ena <= 1'b0;
               end
            end
            SETTLE: begin
               amp_ena <= 1'b1;
               if (cnt == '0) begin
                  state <= VALID;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            VALID: begin
               amp_ena <= 1'b1;
               if (handshake) begin
                  sample_cnt <= sample_cnt + CNT_W'(1);
                  if (cfg_hold == '0) begin
                     state   <= IDLE;
                     amp_ena <= 1'b0;
                  end else begin
                     state <= HOLD;
                     cnt   <= CW'(cfg_hold);
                  end
               end
            end
            HOLD: begin
               // A request on the expiry cycle wins over returning to IDLE.
               if (accept) begin
                  state   <= VALID;
                  amp_ena <= 1'b1;
               end else if (cnt == '0) begin
                  state   <= IDLE;
                  amp_ena <= 1'b0;
               end else begin
                  cnt     <= cnt - CW'(1);
                  amp_ena <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               amp_ena <= 1'b0;
            end
         endcase
      end
   end

endmodule
